// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module  : mc_control
// Brief   : Multi-cycle RV32I-subset sequencer (Moore FSM). It shares one
//           memory port for fetch and load/store and traps on illegal
//           encodings or memory timeouts.
// Revision: 1.0 - initial release
// ============================================================================
module mc_control #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       retire,
  output logic       trap,
  output logic       bus_err
);

  localparam logic [6:0] c_OP_LW = 7'b0000011;
  localparam logic [6:0] c_OP_SW = 7'b0100011;
  localparam logic [6:0] c_OP_R  = 7'b0110011;
  localparam logic [6:0] c_OP_I  = 7'b0010011;
  localparam logic [6:0] c_OP_BR = 7'b1100011;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
  } ctrl_t;

  function automatic logic [2:0] f_alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b111:  return c_ALU_AND;
      3'b110:  return c_ALU_OR;
      3'b010:  return c_ALU_SLT;
      default: return sub ? c_ALU_SUB : c_ALU_ADD;
    endcase
  endfunction

  // Moore outputs of a state; registered from the next state so they are glitch-free.
  function automatic ctrl_t f_ctrl(input state_t s, input logic [2:0] f3, input logic f7);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE: begin c.src_a = 2'b01; c.src_b = 2'b01; end
      S_MEMADR: begin c.src_a = 2'b10; c.src_b = 2'b01; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:  begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
      S_EXECR:  begin c.src_a = 2'b10; c.alu = f_alu_op(f3, f7); end
      S_EXECI:  begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu = f_alu_op(f3, 1'b0); end
      S_ALUWB:  c.reg_write = 1'b1;
      S_BRANCH: begin c.src_a = 2'b10; c.alu = c_ALU_SUB; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic [7:0] r_wait_cnt;
  logic       r_trap;
  logic       r_bus_err;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_alu_f3;
  logic       w_legal_r;
  logic       w_taken;
  logic       w_enter_mem;

  always_comb begin
    w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // A ready arriving on the final allowed cycle completes the access normally.
    w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == c_WAIT_LAST);
    w_alu_f3    = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                  (funct3 == 3'b010);
    w_legal_r   = w_alu_f3 && (!funct7b5 || (funct3 == 3'b000));
    w_taken     = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if ((opcode == c_OP_LW || opcode == c_OP_SW) && funct3 == 3'b010) w_next = S_MEMADR;
        else if (opcode == c_OP_R && w_legal_r)                           w_next = S_EXECR;
        else if (opcode == c_OP_I && w_alu_f3)                            w_next = S_EXECI;
        else if (opcode == c_OP_BR && funct3[2:1] == 2'b00)               w_next = S_BRANCH;
        else                                                              w_next = S_TRAP;
      end
      S_MEMADR: w_next = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXECR,
      S_EXECI:  w_next = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
    if (w_timeout) w_next = S_TRAP;

    w_enter_mem = (w_next != r_state) &&
                  ((w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_ctrl     <= f_ctrl(S_FETCH, 3'b000, 1'b0);
      r_wait_cnt <= '0;
      r_trap     <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_ctrl(w_next, funct3, funct7b5);
      if (w_next == S_TRAP) r_trap    <= 1'b1;
      if (w_timeout)        r_bus_err <= 1'b1;
      if (w_enter_mem)
        r_wait_cnt <= '0;
      else if (w_mem_state && !mem_ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Reset holds FETCH's select values, so the request strobe must be masked explicitly.
  assign mem_req    = r_ctrl.mem_req && !reset;
  assign mem_we     = r_ctrl.mem_we && !reset;
  assign adr_src    = r_ctrl.adr_src;
  assign reg_write  = r_ctrl.reg_write && !reset;
  assign result_src = r_ctrl.result_src;
  assign alu_src_a  = r_ctrl.src_a;
  assign alu_src_b  = r_ctrl.src_b;
  assign alu_ctrl   = r_ctrl.alu;
  assign trap       = r_trap;
  assign bus_err    = r_bus_err;

  assign ir_write = !reset && (r_state == S_FETCH) && mem_ready;
  assign pc_write = !reset && (((r_state == S_FETCH) && mem_ready) ||
                               ((r_state == S_BRANCH) && w_taken));
  assign retire   = !reset && ((r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                               (r_state == S_BRANCH) || ((r_state == S_MEMWR) && mem_ready));

endmodule
`default_nettype wire
